// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one ROM address port among NUM_REQ requesters.
// Issues one read at a time, waits out ROM_LAT edges, then returns the data to its owner.
//   state      | meaning
//   ST_IDLE    | accepting requests; a set req starts a grant
//   ST_WAIT    | address on the ROM, lat_cnt counting down the read latency
//   ST_CAPTURE | rom_data valid this edge; capture it and pulse rd_valid
module rom_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [ADDR_W-1:0]         rom_address_o,
  input  logic [DATA_W-1:0]         rom_data_i,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic [NUM_REQ-1:0]        rd_valid_o,
  output logic                      busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_last_q, rr_last_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                busy_q, busy_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [ADDR_W-1:0]   win_addr;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan starts just past the last winner; only the winner's address slice is read.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req_i[IDX_W'((int'(rr_last_q) + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(rr_last_q) + k) % NUM_REQ);
        win_addr  = req_addr_i[((int'(rr_last_q) + k) % NUM_REQ) * ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_last_d     = rr_last_q;
    lat_cnt_d     = lat_cnt_q;
    gnt_d         = '0;
    rd_valid_d    = '0;
    rom_address_d = rom_address_q;
    rd_data_d     = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_d         = onehot(win_idx);
          rom_address_d = win_addr;
          owner_d       = win_idx;
          rr_last_d     = win_idx;
          lat_cnt_d     = LAT_W'(ROM_LAT);
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rd_data_d  = rom_data_i;
        rd_valid_d = onehot(owner_q);
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      rr_last_q     <= IDX_W'(NUM_REQ - 1);
      lat_cnt_q     <= '0;
      gnt_q         <= '0;
      rd_valid_q    <= '0;
      rom_address_q <= '0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_last_q     <= rr_last_d;
      lat_cnt_q     <= lat_cnt_d;
      gnt_q         <= gnt_d;
      rd_valid_q    <= rd_valid_d;
      rom_address_q <= rom_address_d;
      rd_data_q     <= rd_data_d;
      busy_q        <= busy_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign rd_valid_o    = rd_valid_q;
  assign rom_address_o = rom_address_q;
  assign rd_data_o     = rd_data_q;
  assign busy_o        = busy_q;

endmodule
